// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
//   bcd_state_e   : controller states IDLE, CALC, FIX, DONE
//   bcd_digit_t   : one packed BCD digit
//   BCD_MAX_DIGIT : largest legal BCD digit value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } bcd_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor: d = a_d - b_d - bin, corrected into 0..9.
// Ports:
//   a_d  : minuend digit (0..9)
//   b_d  : subtrahend digit (0..9)
//   bin  : borrow in from the next-lower digit
//   d    : result digit (0..9)
//   bout : borrow out (raw difference was negative)
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_d,
  input  bcd_digit_t b_d,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  // Range of t is -10..9, which fits a 5-bit signed value.
  logic signed [4:0] t;
  logic signed [4:0] t_adj;

  always_comb begin
    t     = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bin});
    t_adj = t + 5'sd10;
    bout  = t[4];
    d     = bout ? t_adj[3:0] : t[3:0];
  end

endmodule

// File: rtl/bcd_subtractor_seq.sv
// Sequential packed-BCD subtractor, one digit per clock, LSD first.
// Optional feature macro: BCD_SIGN_MAG_EN -- when defined, a negative result is turned
// into its magnitude in a second digit-serial pass (FIX) and neg is raised.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request, sampled only in IDLE
//   a, b    : minuend / subtrahend, packed BCD, LSD in [3:0]
//   diff    : packed BCD result
//   borrow  : borrow out of the MSD (a < b)
//   neg     : sign flag (only with BCD_SIGN_MAG_EN)
//   invalid : an operand digit exceeded 9
//   busy    : operation in progress
//   done    : one-cycle result-valid pulse
module bcd_subtractor_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] a,
  input  logic [4*NUM_DIGITS-1:0] b,
  output logic [4*NUM_DIGITS-1:0] diff,
  output logic                    borrow,
  output logic                    neg,
  output logic                    invalid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned W     = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  bcd_state_e       state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             bad_q;
  logic [IDX_W-1:0] idx;
  logic             bin_q;
  logic             ops_bad;
  bcd_digit_t       sub_a;
  bcd_digit_t       sub_b;
  bcd_digit_t       sub_d;
  logic             sub_bout;

`ifdef BCD_SIGN_MAG_EN
  logic neg_q;
  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  // Operand check on the raw inputs, used at the accepting edge.
  always_comb begin
    ops_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[i*4 +: 4] > BCD_MAX_DIGIT || b[i*4 +: 4] > BCD_MAX_DIGIT) ops_bad = 1'b1;
    end
  end

  // The single digit subtractor is shared: CALC feeds a_i - b_i, FIX feeds 0 - diff_i.
  always_comb begin
    sub_a = a_q[idx*4 +: 4];
    sub_b = b_q[idx*4 +: 4];
`ifdef BCD_SIGN_MAG_EN
    if (state == FIX) begin
      sub_a = '0;
      sub_b = diff[idx*4 +: 4];
    end
`endif
  end

  bcd_digit_sub u_digit_sub (
    .a_d  (sub_a),
    .b_d  (sub_b),
    .bin  (bin_q),
    .d    (sub_d),
    .bout (sub_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      bad_q   <= 1'b0;
      idx     <= '0;
      bin_q   <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bad_q   <= ops_bad;
            idx     <= '0;
            bin_q   <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
            invalid <= 1'b0;
            busy    <= 1'b1;
`ifdef BCD_SIGN_MAG_EN
            neg_q   <= 1'b0;
`endif
            state   <= CALC;
          end
        end
        CALC: begin
          if (bad_q) begin
            // Rejected operands spend one cycle here without touching diff.
            invalid <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            diff[idx*4 +: 4] <= sub_d;
            bin_q            <= sub_bout;
            if (idx == LAST_IDX) begin
              borrow <= sub_bout;
              idx    <= '0;
              bin_q  <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
              if (sub_bout) begin
                state <= FIX;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
`ifdef BCD_SIGN_MAG_EN
        FIX: begin
          // Ten's complement of the raw result yields the magnitude.
          diff[idx*4 +: 4] <= sub_d;
          bin_q            <= sub_bout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            bin_q <= 1'b0;
            neg_q <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq: directed and random operands, a
// queue-based scoreboard fed by the stimulus and drained by a done-driven monitor.
module tb_bcd_subtractor_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         neg;
  logic         invalid;
  logic         busy;
  logic         done;

  bcd_subtractor_seq #(.NUM_DIGITS(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .diff    (diff),
    .borrow  (borrow),
    .neg     (neg),
    .invalid (invalid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // lat: rising edges after the accepting edge until done is visible (the spec's
  // "done at edge K" is the edge that samples it, i.e. K = lat + 1).
  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         neg;
    logic         invalid;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: whole-number subtraction on the decimal values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   p = 1;
    int   d;
    bit   bad = 0;
    for (int i = 0; i < N; i++) begin
      p = p * 10;
      if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) bad = 1;
    end
    e.diff = '0; e.borrow = 0; e.neg = 0; e.invalid = 0; e.acc = 0; e.lat = N;
    if (bad) begin
      e.invalid = 1;
      e.lat = 1;
      return e;
    end
    d = bcd2int(x) - bcd2int(y);
    if (d >= 0) begin
      e.diff = int2bcd(d);
    end else begin
      e.borrow = 1;
`ifdef BCD_SIGN_MAG_EN
      e.diff = int2bcd(-d);
      e.neg  = 1;
      e.lat  = 2 * N;
`else
      e.diff = int2bcd(d + p);
`endif
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        chk("diff", diff, mon_e.diff);
        chk("borrow", borrow, mon_e.borrow);
        chk("neg", neg, mon_e.neg);
        chk("invalid", invalid, mon_e.invalid);
        chk("busy_in_done", busy, 0);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // mode 0: plain, 1: output hold check, 2: start pulse during CALC, 3: start during DONE
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    exp_t e;
    int   waited = 0;
    e = model(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e.acc = cyc;
    exp_q.push_back(e);
    chk("busy_after_accept", busy, 1);
    if (mode == 2) begin
      @(negedge clk);
      a = 16'h8888; b = 16'h1111; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      waited = 1;
    end
    if (mode == 3) begin
      repeat (e.lat) @(posedge clk);
      @(negedge clk);
      chk("done_pulse", done, 1);
      a = 16'h0002; b = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2 * N + 4) @(posedge clk);
      #1 chk("start_in_done_ignored", busy, 0);
      chk("result_pending", exp_q.size(), 0);
      return;
    end
    repeat (e.lat + 2 - waited) @(posedge clk);
    #1 chk("result_pending", exp_q.size(), 0);
    if (mode == 1) begin
      a = ~x; b = ~y;
      repeat (3) @(posedge clk);
      #1 chk("hold_diff", diff, e.diff);
      chk("hold_flags", {borrow, neg, invalid}, {e.borrow, e.neg, e.invalid});
    end
  endtask

  task automatic run_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < N; i++) begin
      x[i*4 +: 4] = 4'($urandom_range(0, 9));
      y[i*4 +: 4] = 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) x[$urandom_range(0, N - 1)*4 +: 4] = 4'($urandom_range(10, 15));
      else y[$urandom_range(0, N - 1)*4 +: 4] = 4'($urandom_range(10, 15));
    end
    run_op(x, y, 0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL timeout: got no end of test expected finish within bound");
    $fatal(1, "bench timeout");
  end

  initial begin
    #2;
    chk("reset_outputs", {diff, borrow, neg, invalid, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h4321, 16'h1234, 1);
    run_op(16'h0000, 16'h0001, 1);
    run_op(16'h9999, 16'h9999, 0);
    run_op(16'h1000, 16'h0001, 0);
    run_op(16'h12A4, 16'h0001, 1);
    run_op(16'h4321, 16'h1234, 2);
    run_op(16'h0005, 16'h0007, 3);

    // Reset in the second CALC cycle discards the operation.
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_calc", {diff, borrow, neg, invalid, busy, done}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * N) @(posedge clk);
    #1 chk("no_done_after_reset", busy, 0);
    run_op(16'h0042, 16'h0017, 0);

    for (int k = 0; k < 50; k++) run_random();

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
